// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_bus_arbiter
//  Purpose  : Grants the single SDRAM-controller port to either the ICache or
//             the DCache, muxes the owner's address/control onto the
//             controller side, inserts a turnaround cycle between owners,
//             limits ICache starvation and aborts hung bursts.
//  Revision : 1.0  initial release
// ============================================================================
module mem_bus_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 1024,
    parameter int AW         = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_istrobe,
    input  logic [AW-1:0] i_iaddress,
    input  logic          i_dstrobe,
    input  logic          i_drw,
    input  logic [3:0]    i_dbe,
    input  logic [AW-1:0] i_daddress,
    input  logic          i_sdone,
    output logic          o_igrant,
    output logic          o_dgrant,
    output logic          o_sstrobe,
    output logic          o_srw,
    output logic [3:0]    o_sbe,
    output logic [AW-1:0] o_saddress,
    output logic          o_buserr
);

    localparam int c_STREAK_W = $clog2(STARVE_MAX + 1);
    localparam int c_WD_W     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [c_STREAK_W-1:0] c_STARVE  = c_STREAK_W'(STARVE_MAX);
    localparam logic [c_WD_W-1:0]     c_WD_LAST = c_WD_W'(TIMEOUT - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_GNT_D = 2'd1;
    localparam logic [1:0] c_GNT_I = 2'd2;
    localparam logic [1:0] c_TURN  = 2'd3;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic                  w_abort;
    logic                  r_igrant;
    logic                  r_dgrant;
    logic                  r_buserr;
    logic                  w_igrant_nxt;
    logic                  w_dgrant_nxt;
    logic                  w_buserr_nxt;
    logic [c_STREAK_W-1:0] r_streak;
    logic [c_WD_W-1:0]     r_wd;
    logic                  w_in_gnt;
    logic                  w_stay_gnt;

    assign w_in_gnt   = (r_state == c_GNT_D) || (r_state == c_GNT_I);
    assign w_stay_gnt = w_in_gnt && (w_state_nxt == r_state);

    // State register plus the registered grant / error outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_IDLE;
            r_igrant <= 1'b0;
            r_dgrant <= 1'b0;
            r_buserr <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_igrant <= w_igrant_nxt;
            r_dgrant <= w_dgrant_nxt;
            r_buserr <= w_buserr_nxt;
        end
    end

    // Next-state: arbitrate in IDLE, hold the grant until SDone or watchdog
    always_comb begin
        w_state_nxt = r_state;
        w_abort     = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (i_dstrobe && i_istrobe) begin
                    w_state_nxt = (r_streak == c_STARVE) ? c_GNT_I : c_GNT_D;
                end else if (i_dstrobe) begin
                    w_state_nxt = c_GNT_D;
                end else if (i_istrobe) begin
                    w_state_nxt = c_GNT_I;
                end
            end
            c_GNT_D, c_GNT_I: begin
                // SDone wins over a simultaneous watchdog expiry
                if (i_sdone) begin
                    w_state_nxt = c_TURN;
                end else if (r_wd == c_WD_LAST) begin
                    w_state_nxt = c_TURN;
                    w_abort     = 1'b1;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Output decode of the next state, captured by the state register
    always_comb begin
        w_igrant_nxt = (w_state_nxt == c_GNT_I);
        w_dgrant_nxt = (w_state_nxt == c_GNT_D);
        w_buserr_nxt = w_abort;
    end

    // Starvation streak: counts DCache wins taken while ICache was waiting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_streak <= '0;
        end else if (r_state == c_IDLE) begin
            if (w_state_nxt == c_GNT_D) begin
                if (!i_istrobe) begin
                    r_streak <= '0;
                end else if (r_streak != c_STARVE) begin
                    r_streak <= r_streak + c_STREAK_W'(1);
                end
            end else if (w_state_nxt == c_GNT_I) begin
                r_streak <= '0;
            end
        end
    end

    // Watchdog: runs only while a grant persists, zero everywhere else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd <= '0;
        end else if (w_stay_gnt) begin
            r_wd <= r_wd + c_WD_W'(1);
        end else begin
            r_wd <= '0;
        end
    end

    // Controller-side mux driven straight from the grant registers
    always_comb begin
        o_igrant   = r_igrant;
        o_dgrant   = r_dgrant;
        o_buserr   = r_buserr;
        o_sstrobe  = r_igrant | r_dgrant;
        o_srw      = r_dgrant ? i_drw : 1'b1;
        o_sbe      = r_dgrant ? i_dbe : 4'hF;
        o_saddress = r_dgrant ? i_daddress : (r_igrant ? i_iaddress : '0);
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_bus_arbiter
//  Purpose  : Self-checking bench for mem_bus_arbiter. Expected grants are
//             queued when requests are driven and popped when a grant appears.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_bus_arbiter;

    localparam int STARVE_MAX = 4;
    localparam int TIMEOUT    = 1024;
    localparam int AW         = 32;

    logic          clk;
    logic          rst_n;
    logic          i_istrobe;
    logic [AW-1:0] i_iaddress;
    logic          i_dstrobe;
    logic          i_drw;
    logic [3:0]    i_dbe;
    logic [AW-1:0] i_daddress;
    logic          i_sdone;
    logic          o_igrant;
    logic          o_dgrant;
    logic          o_sstrobe;
    logic          o_srw;
    logic [3:0]    o_sbe;
    logic [AW-1:0] o_saddress;
    logic          o_buserr;

    typedef struct packed {
        logic          is_i;
        logic [AW-1:0] addr;
        logic          rw;
        logic [3:0]    be;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    mem_bus_arbiter #(
        .STARVE_MAX (STARVE_MAX),
        .TIMEOUT    (TIMEOUT),
        .AW         (AW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_istrobe  (i_istrobe),
        .i_iaddress (i_iaddress),
        .i_dstrobe  (i_dstrobe),
        .i_drw      (i_drw),
        .i_dbe      (i_dbe),
        .i_daddress (i_daddress),
        .i_sdone    (i_sdone),
        .o_igrant   (o_igrant),
        .o_dgrant   (o_dgrant),
        .o_sstrobe  (o_sstrobe),
        .o_srw      (o_srw),
        .o_sbe      (o_sbe),
        .o_saddress (o_saddress),
        .o_buserr   (o_buserr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Step one clock and settle just after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_vec++;
        if ({o_igrant, o_dgrant, o_sstrobe, o_buserr} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_flags: got %b required 0000", {o_igrant, o_dgrant, o_sstrobe, o_buserr});
        end
        n_vec++;
        if (o_saddress !== '0 || o_srw !== 1'b1 || o_sbe !== 4'hF) begin
            n_err++;
            $display("FAIL reset_bus: got addr=%h rw=%b be=%h required 0/1/F", o_saddress, o_srw, o_sbe);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_dcache_write();
        exp_t e;
        bit   held;
        i_dstrobe  = 1'b1;
        i_drw      = 1'b0;
        i_dbe      = 4'h3;
        i_daddress = 32'h0000_1008;
        sb.push_back('{1'b0, 32'h0000_1008, 1'b0, 4'h3});
        n_vec++;
        if (o_sstrobe !== 1'b0) begin
            n_err++;
            $display("FAIL dwr_no_comb_grant: got sstrobe=%b required 0", o_sstrobe);
        end
        tick();
        e = sb.pop_front();
        n_vec++;
        if (o_dgrant !== 1'b1 || o_igrant !== 1'b0 || o_sstrobe !== 1'b1) begin
            n_err++;
            $display("FAIL dwr_grant: got d=%b i=%b s=%b required 1/0/1", o_dgrant, o_igrant, o_sstrobe);
        end
        n_vec++;
        if (o_saddress !== e.addr || o_srw !== e.rw || o_sbe !== e.be) begin
            n_err++;
            $display("FAIL dwr_bus: got addr=%h rw=%b be=%h required %h/%b/%h", o_saddress, o_srw, o_sbe, e.addr, e.rw, e.be);
        end
        held = 1'b1;
        repeat (5) begin
            tick();
            if (o_dgrant !== 1'b1) held = 1'b0;
        end
        n_vec++;
        if (!held) begin
            n_err++;
            $display("FAIL dwr_hold: got grant dropped before SDone, required held");
        end
        i_sdone = 1'b1;
        tick();
        i_sdone = 1'b0;
        n_vec++;
        if (o_dgrant !== 1'b0 || o_sstrobe !== 1'b0) begin
            n_err++;
            $display("FAIL dwr_release: got d=%b s=%b required 0/0", o_dgrant, o_sstrobe);
        end
        // Strobe stays high: the turnaround cycle must precede the re-grant
        sb.push_back('{1'b0, 32'h0000_1008, 1'b0, 4'h3});
        tick();
        n_vec++;
        if (o_sstrobe !== 1'b0) begin
            n_err++;
            $display("FAIL dwr_turn: got sstrobe=%b required 0", o_sstrobe);
        end
        tick();
        e = sb.pop_front();
        n_vec++;
        if (o_dgrant !== 1'b1 || o_saddress !== e.addr) begin
            n_err++;
            $display("FAIL dwr_regrant: got d=%b addr=%h required 1/%h", o_dgrant, o_saddress, e.addr);
        end
        i_sdone = 1'b1;
        tick();
        i_sdone   = 1'b0;
        i_dstrobe = 1'b0;
        tick();
    endtask

    task automatic test_simultaneous();
        exp_t e;
        int   m_streak;
        int   w;
        m_streak   = 0;
        i_istrobe  = 1'b1;
        i_iaddress = 32'h0040_1000;
        i_dstrobe  = 1'b1;
        i_drw      = 1'b0;
        i_dbe      = 4'hC;
        i_daddress = 32'h2000_0040;
        for (int k = 0; k < 7; k++) begin
            if (m_streak == STARVE_MAX) begin
                sb.push_back('{1'b1, 32'h0040_1000, 1'b1, 4'hF});
                m_streak = 0;
            end else begin
                sb.push_back('{1'b0, 32'h2000_0040, 1'b0, 4'hC});
                m_streak = m_streak + 1;
            end
        end
        for (int k = 0; k < 7; k++) begin
            w = 0;
            while (w < 8) begin
                tick();
                w++;
                if (o_sstrobe) break;
            end
            e = sb.pop_front();
            n_vec++;
            if (o_sstrobe !== 1'b1 || w != ((k == 0) ? 1 : 2)) begin
                n_err++;
                $display("FAIL sim_latency[%0d]: got %0d cycles (sstrobe=%b) required %0d", k, w, o_sstrobe, (k == 0) ? 1 : 2);
            end
            n_vec++;
            if (o_igrant !== e.is_i || o_dgrant !== !e.is_i) begin
                n_err++;
                $display("FAIL sim_owner[%0d]: got i=%b d=%b required i=%b", k, o_igrant, o_dgrant, e.is_i);
            end
            n_vec++;
            if (o_saddress !== e.addr || o_srw !== e.rw || o_sbe !== e.be) begin
                n_err++;
                $display("FAIL sim_bus[%0d]: got addr=%h rw=%b be=%h required %h/%b/%h", k, o_saddress, o_srw, o_sbe, e.addr, e.rw, e.be);
            end
            tick();
            tick();
            i_sdone = 1'b1;
            tick();
            i_sdone = 1'b0;
            if (k == 6) begin
                i_istrobe = 1'b0;
                i_dstrobe = 1'b0;
            end
        end
        n_vec++;
        if (dut.r_streak !== 3'(m_streak)) begin
            n_err++;
            $display("FAIL sim_streak: got %0d required %0d", dut.r_streak, m_streak);
        end
        tick();
    endtask

    task automatic test_icache_only();
        exp_t e;
        i_istrobe  = 1'b1;
        i_iaddress = 32'h0040_0000;
        sb.push_back('{1'b1, 32'h0040_0000, 1'b1, 4'hF});
        tick();
        e = sb.pop_front();
        n_vec++;
        if (o_igrant !== 1'b1 || o_dgrant !== 1'b0 || o_saddress !== e.addr || o_srw !== e.rw || o_sbe !== e.be) begin
            n_err++;
            $display("FAIL ionly_grant: got i=%b d=%b addr=%h rw=%b be=%h required 1/0/%h/1/F", o_igrant, o_dgrant, o_saddress, o_srw, o_sbe, e.addr);
        end
        n_vec++;
        if (dut.r_streak !== 3'd0) begin
            n_err++;
            $display("FAIL ionly_streak: got %0d required 0", dut.r_streak);
        end
        tick();
    endtask

    task automatic test_reset_mid_burst();
        exp_t e;
        rst_n = 1'b0;
        #2;
        n_vec++;
        if (o_igrant !== 1'b0 || o_sstrobe !== 1'b0 || o_saddress !== '0) begin
            n_err++;
            $display("FAIL rst_async: got i=%b s=%b addr=%h required 0/0/0", o_igrant, o_sstrobe, o_saddress);
        end
        n_vec++;
        if (o_srw !== 1'b1 || o_sbe !== 4'hF || o_buserr !== 1'b0) begin
            n_err++;
            $display("FAIL rst_async_ctl: got rw=%b be=%h err=%b required 1/F/0", o_srw, o_sbe, o_buserr);
        end
        i_istrobe  = 1'b0;
        i_dstrobe  = 1'b1;
        i_drw      = 1'b1;
        i_dbe      = 4'h5;
        i_daddress = 32'h0000_3000;
        sb.push_back('{1'b0, 32'h0000_3000, 1'b1, 4'h5});
        #2;
        rst_n = 1'b1;
        tick();
        e = sb.pop_front();
        n_vec++;
        if (o_dgrant !== 1'b1 || o_saddress !== e.addr || o_srw !== e.rw || o_sbe !== e.be) begin
            n_err++;
            $display("FAIL rst_regrant: got d=%b addr=%h rw=%b be=%h required 1/%h/%b/%h", o_dgrant, o_saddress, o_srw, o_sbe, e.addr, e.rw, e.be);
        end
        n_vec++;
        if (dut.r_streak !== 3'd0) begin
            n_err++;
            $display("FAIL rst_streak: got %0d required 0", dut.r_streak);
        end
        i_sdone = 1'b1;
        tick();
        i_sdone   = 1'b0;
        i_dstrobe = 1'b0;
        tick();
    endtask

    task automatic test_stray_sdone();
        i_sdone = 1'b1;
        tick();
        i_sdone = 1'b0;
        n_vec++;
        if (o_sstrobe !== 1'b0 || o_buserr !== 1'b0) begin
            n_err++;
            $display("FAIL stray_sdone: got s=%b err=%b required 0/0", o_sstrobe, o_buserr);
        end
        // Still in IDLE: a new request must be granted after one cycle
        i_dstrobe  = 1'b1;
        i_daddress = 32'h0000_5550;
        tick();
        n_vec++;
        if (o_dgrant !== 1'b1 || o_buserr !== 1'b0) begin
            n_err++;
            $display("FAIL stray_idle: got d=%b err=%b required 1/0", o_dgrant, o_buserr);
        end
        i_sdone = 1'b1;
        tick();
        i_sdone   = 1'b0;
        i_dstrobe = 1'b0;
        tick();
    endtask

    task automatic test_watchdog();
        exp_t e;
        int   cnt;
        i_dstrobe  = 1'b1;
        i_drw      = 1'b0;
        i_dbe      = 4'hF;
        i_daddress = 32'h0000_4000;
        sb.push_back('{1'b0, 32'h0000_4000, 1'b0, 4'hF});
        tick();
        e = sb.pop_front();
        n_vec++;
        if (o_dgrant !== 1'b1 || o_saddress !== e.addr) begin
            n_err++;
            $display("FAIL wd_grant: got d=%b addr=%h required 1/%h", o_dgrant, o_saddress, e.addr);
        end
        i_istrobe  = 1'b1;
        i_iaddress = 32'h0040_2000;
        sb.push_back('{1'b1, 32'h0040_2000, 1'b1, 4'hF});
        cnt = 1;
        while (cnt < TIMEOUT + 80) begin
            tick();
            if (o_dgrant) cnt++;
            else break;
        end
        n_vec++;
        if (cnt != TIMEOUT || o_dgrant !== 1'b0) begin
            n_err++;
            $display("FAIL wd_length: got %0d grant cycles (d=%b) required %0d", cnt, o_dgrant, TIMEOUT);
        end
        n_vec++;
        if (o_buserr !== 1'b1) begin
            n_err++;
            $display("FAIL wd_buserr: got %b required 1", o_buserr);
        end
        i_dstrobe = 1'b0;
        tick();
        n_vec++;
        if (o_buserr !== 1'b0 || o_sstrobe !== 1'b0) begin
            n_err++;
            $display("FAIL wd_buserr_pulse: got err=%b s=%b required 0/0", o_buserr, o_sstrobe);
        end
        tick();
        e = sb.pop_front();
        n_vec++;
        if (o_igrant !== 1'b1 || o_saddress !== e.addr || o_srw !== e.rw || o_sbe !== e.be) begin
            n_err++;
            $display("FAIL wd_next_grant: got i=%b addr=%h rw=%b be=%h required 1/%h/1/F", o_igrant, o_saddress, o_srw, o_sbe, e.addr);
        end
        i_sdone = 1'b1;
        tick();
        i_sdone   = 1'b0;
        i_istrobe = 1'b0;
        tick();
    endtask

    task automatic test_sdone_at_expiry();
        i_dstrobe  = 1'b1;
        i_daddress = 32'h0000_6000;
        tick();
        n_vec++;
        if (o_dgrant !== 1'b1) begin
            n_err++;
            $display("FAIL exp_grant: got d=%b required 1", o_dgrant);
        end
        repeat (TIMEOUT - 1) tick();
        n_vec++;
        if (o_dgrant !== 1'b1 || o_buserr !== 1'b0) begin
            n_err++;
            $display("FAIL exp_last_cycle: got d=%b err=%b required 1/0", o_dgrant, o_buserr);
        end
        i_sdone = 1'b1;
        tick();
        i_sdone   = 1'b0;
        i_dstrobe = 1'b0;
        n_vec++;
        if (o_dgrant !== 1'b0 || o_buserr !== 1'b0) begin
            n_err++;
            $display("FAIL exp_sdone_wins: got d=%b err=%b required 0/0", o_dgrant, o_buserr);
        end
        tick();
    endtask

    // Hard stop if the sequence ever stalls
    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no end of run, required completion");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst_n      = 1'b0;
        i_istrobe  = 1'b0;
        i_iaddress = '0;
        i_dstrobe  = 1'b0;
        i_drw      = 1'b1;
        i_dbe      = 4'h0;
        i_daddress = '0;
        i_sdone    = 1'b0;
        test_reset();
        test_dcache_write();
        test_simultaneous();
        test_icache_only();
        test_reset_mid_burst();
        test_stray_sdone();
        test_watchdog();
        test_sdone_at_expiry();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Arbitrates the single SDRAM-controller port between the instruction cache and the data cache (including its write-buffer flushes). It grants ownership of the memory bus to one requester per transaction and muxes that requester's address and control onto the controller side. It holds the grant until the controller signals completion and inserts a turnaround cycle between owners. A starvation limiter and a watchdog bound how long either side can wait or hold the bus.

## Interface
- STARVE_MAX, 4: consecutive DCache grants allowed while IStrobe is pending; the next grant then goes to ICache.
- TIMEOUT, 1024: maximum cycles a grant may wait for SDone before it is aborted.
- AW, 32: address width.

- Clk  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- IStrobe  in  1  ICache request, level; held until IGrant falls.
- IAddress  in  AW  ICache burst address; stable while IStrobe is high.
- DStrobe  in  1  DCache request, level; held until DGrant falls.
- DRW  in  1  DCache direction: 1 = read, 0 = write.
- DBE  in  4  DCache byte enables.
- DAddress  in  AW  DCache address; stable while DStrobe is high.
- SDone  in  1  one-cycle pulse from the SDRAM controller: burst finished.
- IGrant  out  1  ICache owns the bus, registered.
- DGrant  out  1  DCache owns the bus, registered.
- SStrobe  out  1  request to the controller; equals IGrant | DGrant.
- SRW  out  1  DRW when DGrant; 1 when IGrant; 1 when idle.
- SBE  out  4  DBE when DGrant; 4'hF otherwise.
- SAddress  out  AW  address of the owner; 0 when no grant.
- BusErr  out  1  one-cycle pulse on watchdog abort, registered.

## Operation
- FSM states:
  - IDLE: no grant.
  - GNT_D: DGrant = 1.
  - GNT_I: IGrant = 1.
  - TURN: one dead cycle, no grant.
- IDLE transitions:
  - Only DStrobe high → GNT_D.
  - Only IStrobe high → GNT_I.
  - Both high → GNT_D, unless streak == STARVE_MAX, then GNT_I.
  - Neither high → stay in IDLE.
- GNT_x transitions:
  - SDone = 1 → TURN.
  - Watchdog reaches TIMEOUT-1 without SDone → TURN, and BusErr pulses.
- TURN → IDLE unconditionally. The cycle is for tri-state turnaround on the shared data bus; re-arbitration happens in IDLE.
- streak counter, width clog2(STARVE_MAX+1):
  - On entry to GNT_D with IStrobe high → streak+1, saturating at STARVE_MAX.
  - On entry to GNT_D with IStrobe low → streak = 0.
  - On entry to GNT_I → streak = 0.
- Watchdog counter:
  - Clears on entry to any GNT state and increments each cycle in that state.
  - Width clog2(TIMEOUT).
  - Never runs in IDLE or TURN.
- Strobes that drop while not granted are ignored; no request is latched.
- Strobes that drop during a grant do not end the grant; only SDone or the watchdog ends it.
- The block does not route data. Each cache drives the shared MData only while its own grant is high.
- Reset (Reset = 0), asynchronous and valid mid-transaction:
  - State = IDLE; streak = 0; watchdog = 0.
  - IGrant, DGrant, SStrobe, BusErr = 0; SAddress = 0; SRW = 1; SBE = 4'hF.

## Timing
- Grant latency: a strobe sampled high in IDLE at edge N gives Grant = 1 after edge N, so the earliest SStrobe is one cycle after the request.
- SAddress, SRW and SBE are combinational from the grant registers and are valid in the same cycle SStrobe rises.
- SDone sampled at edge M: the grant falls after edge M, TURN occupies cycle M+1, and IDLE can re-grant at edge M+2. Minimum gap between two grants is 2 cycles.
- SDone arriving in IDLE or TURN is ignored.
- SDone on the same edge as the watchdog expiry counts as normal completion; BusErr stays 0.
- BusErr is high for exactly the cycle the state is TURN after an abort.

## Test plan
- Single DCache write: DStrobe = 1, DRW = 0, DBE = 4'h3, DAddress = 32'h0000_1008, SDone 6 cycles after DGrant.
  - Required: DGrant and SStrobe rise 1 cycle after the request, with SAddress = 32'h1008, SRW = 0, SBE = 4'h3.
  - Required: DGrant falls 1 cycle after SDone, and 1 TURN cycle follows.
- Simultaneous requests: IStrobe and DStrobe both held high continuously, SDone 3 cycles into each grant.
  - Required: 4 DCache grants, then 1 ICache grant (IAddress on SAddress, SRW = 1, SBE = 4'hF), and the pattern repeats.
- ICache only: IStrobe = 1, IAddress = 32'h0040_0000, STARVE_MAX = 4.
  - Required: IGrant after 1 cycle, and streak stays 0.
- Watchdog: grant DCache and never assert SDone.
  - Required: after TIMEOUT = 1024 grant cycles, DGrant = 0 and BusErr = 1 for 1 cycle; a pending IStrobe is granted 2 cycles later.
- Reset mid-burst: pull Reset low during GNT_I.
  - Required: IGrant, SStrobe and SAddress go to 0 immediately, without a clock edge.
  - Required: after release with DStrobe high, DGrant rises 1 cycle later and streak = 0.
- Stray completion: pulse SDone in IDLE.
  - Required: no state change and no BusErr.
